// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encodings and the flag-update decode helpers.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;
   localparam logic [3:0] OP_LW     = 4'b1000;
   localparam logic [3:0] OP_SW     = 4'b1001;
   localparam logic [3:0] OP_LHB    = 4'b1010;
   localparam logic [3:0] OP_LLB    = 4'b1011;
   localparam logic [3:0] OP_B      = 4'b1100;
   localparam logic [3:0] OP_BR     = 4'b1101;
   localparam logic [3:0] OP_PCS    = 4'b1110;
   localparam logic [3:0] OP_HLT    = 4'b1111;

   // Arithmetic ops update all three flags.
   function automatic logic sets_nzv(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Logic and shift ops update only the zero flag.
   function automatic logic sets_z_only(input logic [3:0] op);
      return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
   endfunction

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// N/Z/V condition-flag register with opcode-driven update enables.
module flag_reg
   import wisc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         commit,
   input  logic [3:0]   opcode,
   input  logic [W-1:0] result,
   input  logic         ovfl,
   output logic         flag_n,
   output logic         flag_z,
   output logic         flag_v
);

   // Flags change only when an instruction actually commits; others hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_v <= 1'b0;
      end else if (commit) begin
         if (sets_nzv(opcode)) begin
            flag_n <= result[W-1];
            flag_z <= (result == '0);
            flag_v <= ovfl;
         end else if (sets_z_only(opcode)) begin
            flag_z <= (result == '0);
         end
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with condition flags, PADDSB saturation counter
// and sticky halt latch.
module ex_mem_stage
   import wisc_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [3:0]   opcode,
   input  logic [W-1:0] alu_result,
   input  logic         alu_ovfl,
   input  logic [W-1:0] store_data,
   input  logic [3:0]   rd,
   input  logic         reg_wr,
   input  logic         mem_rd,
   input  logic         mem_wr,
   output logic         out_valid,
   output logic [W-1:0] out_result,
   output logic [W-1:0] out_store_data,
   output logic [3:0]   out_rd,
   output logic         out_reg_wr,
   output logic         out_mem_rd,
   output logic         out_mem_wr,
   output logic         flag_n,
   output logic         flag_z,
   output logic         flag_v,
   output logic [15:0]  sat_count,
   output logic         halted
);

   logic commit;
   logic is_hlt;

   // Once halted nothing further commits, so flags freeze and bubbles flow.
   assign commit = in_valid & ~stall & ~flush & ~halted;
   assign is_hlt = (opcode == OP_HLT);

   // Pipeline register: flush kills control, stall holds, bubbles keep data.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid      <= 1'b0;
         out_result     <= '0;
         out_store_data <= '0;
         out_rd         <= '0;
         out_reg_wr     <= 1'b0;
         out_mem_rd     <= 1'b0;
         out_mem_wr     <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         out_reg_wr <= 1'b0;
         out_mem_rd <= 1'b0;
         out_mem_wr <= 1'b0;
      end else if (!stall) begin
         if (commit) begin
            out_valid      <= 1'b1;
            out_result     <= alu_result;
            out_store_data <= store_data;
            out_rd         <= rd;
            // HLT travels on as a valid row with no side effects downstream.
            out_reg_wr     <= reg_wr & ~is_hlt;
            out_mem_rd     <= mem_rd & ~is_hlt;
            out_mem_wr     <= mem_wr & ~is_hlt;
         end else begin
            out_valid  <= 1'b0;
            out_reg_wr <= 1'b0;
            out_mem_rd <= 1'b0;
            out_mem_wr <= 1'b0;
         end
      end
   end

   // Debug counter of committed PADDSB saturations; sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count <= '0;
      end else if (commit && (opcode == OP_PADDSB) && alu_ovfl && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end

   // Sticky halt: set by a committed HLT, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted <= 1'b0;
      end else if (commit && is_hlt) begin
         halted <= 1'b1;
      end
   end

   flag_reg #(.W(W)) u_flag_reg (
      .clk    (clk),
      .rst    (rst),
      .commit (commit),
      .opcode (opcode),
      .result (alu_result),
      .ovfl   (alu_ovfl),
      .flag_n (flag_n),
      .flag_z (flag_z),
      .flag_v (flag_v)
   );

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid;
   logic [3:0]  opcode;
   logic [15:0] alu_result;
   logic        alu_ovfl;
   logic [15:0] store_data;
   logic [3:0]  rd;
   logic        reg_wr, mem_rd, mem_wr;
   logic        out_valid;
   logic [15:0] out_result, out_store_data;
   logic [3:0]  out_rd;
   logic        out_reg_wr, out_mem_rd, out_mem_wr;
   logic        flag_n, flag_z, flag_v;
   logic [15:0] sat_count;
   logic        halted;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic        m_valid, m_reg_wr, m_mem_rd, m_mem_wr;
   logic [15:0] m_result, m_store;
   logic [3:0]  m_rd;
   logic        m_n, m_z, m_v, m_halted;
   int          m_count;

   always #5 clk = ~clk;

   ex_mem_stage #(.W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .in_valid       (in_valid),
      .opcode         (opcode),
      .alu_result     (alu_result),
      .alu_ovfl       (alu_ovfl),
      .store_data     (store_data),
      .rd             (rd),
      .reg_wr         (reg_wr),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .out_valid      (out_valid),
      .out_result     (out_result),
      .out_store_data (out_store_data),
      .out_rd         (out_rd),
      .out_reg_wr     (out_reg_wr),
      .out_mem_rd     (out_mem_rd),
      .out_mem_wr     (out_mem_wr),
      .flag_n         (flag_n),
      .flag_z         (flag_z),
      .flag_v         (flag_v),
      .sat_count      (sat_count),
      .halted         (halted)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one edge using the rules of the stage.
   task automatic model_edge();
      bit committed;
      if (rst) begin
         {m_valid, m_reg_wr, m_mem_rd, m_mem_wr} = '0;
         m_result = 0; m_store = 0; m_rd = 0;
         {m_n, m_z, m_v, m_halted} = '0;
         m_count = 0;
      end else if (flush) begin
         {m_valid, m_reg_wr, m_mem_rd, m_mem_wr} = '0;
      end else if (!stall) begin
         committed = in_valid && !m_halted;
         if (!committed) begin
            {m_valid, m_reg_wr, m_mem_rd, m_mem_wr} = '0;
         end else begin
            m_valid  = 1;
            m_result = alu_result;
            m_store  = store_data;
            m_rd     = rd;
            if (opcode == 4'hF) begin
               {m_reg_wr, m_mem_rd, m_mem_wr} = '0;
               m_halted = 1;
            end else begin
               m_reg_wr = reg_wr; m_mem_rd = mem_rd; m_mem_wr = mem_wr;
            end
            case (opcode)
               4'h0, 4'h1: begin
                  m_n = alu_result[15];
                  m_z = (alu_result == 0);
                  m_v = alu_ovfl;
               end
               4'h2, 4'h4, 4'h5, 4'h6: m_z = (alu_result == 0);
               default: ;
            endcase
            if (opcode == 4'h7 && alu_ovfl && m_count < 65535) m_count++;
         end
      end
   endtask

   task automatic compare_all();
      check("out_valid", 16'(out_valid), 16'(m_valid));
      check("out_result", out_result, m_result);
      check("out_store_data", out_store_data, m_store);
      check("out_rd", 16'(out_rd), 16'(m_rd));
      check("out_reg_wr", 16'(out_reg_wr), 16'(m_reg_wr));
      check("out_mem_rd", 16'(out_mem_rd), 16'(m_mem_rd));
      check("out_mem_wr", 16'(out_mem_wr), 16'(m_mem_wr));
      check("flag_n", 16'(flag_n), 16'(m_n));
      check("flag_z", 16'(flag_z), 16'(m_z));
      check("flag_v", 16'(flag_v), 16'(m_v));
      check("sat_count", sat_count, 16'(m_count));
      check("halted", 16'(halted), 16'(m_halted));
   endtask

   // Apply inputs, clock once, update model, compare 1 time unit later.
   task automatic step(input logic r, input logic s, input logic f, input logic v,
                       input logic [3:0] op, input logic [15:0] res, input logic ov,
                       input logic [15:0] sd, input logic [3:0] d,
                       input logic rw, input logic mr, input logic mw);
      rst = r; stall = s; flush = f; in_valid = v;
      opcode = op; alu_result = res; alu_ovfl = ov;
      store_data = sd; rd = d; reg_wr = rw; mem_rd = mr; mem_wr = mw;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic go(input logic [3:0] op, input logic [15:0] res, input logic ov);
      step(0, 0, 0, 1, op, res, ov, 16'hA5A5, 4'h3, 1, 0, 0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [15:0] sample;

      // Reset
      step(1, 0, 0, 0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 0, 0, 0);
      check("reset_valid", 16'(out_valid), 16'h0);
      check("reset_count", sat_count, 16'h0);

      // SUB with zero result
      go(4'h1, 16'h0000, 0);
      check("sub_z", 16'({flag_n, flag_z, flag_v}), 16'b010);
      check("sub_valid", 16'(out_valid), 16'h1);

      // ADD negative overflow, then XOR nonzero
      go(4'h0, 16'h8000, 1);
      check("add_nzv", 16'({flag_n, flag_z, flag_v}), 16'b101);
      go(4'h2, 16'h0001, 0);
      check("xor_nzv", 16'({flag_n, flag_z, flag_v}), 16'b101);

      // Three PADDSB saturations
      repeat (3) go(4'h7, 16'h7878, 1);
      check("paddsb_count", sat_count, 16'd3);
      check("paddsb_flags", 16'({flag_n, flag_z, flag_v}), 16'b101);

      // Stall two cycles, then stall+flush
      repeat (2) step(0, 1, 0, 1, 4'h0, 16'h1234, 0, 16'h1111, 4'h7, 1, 1, 1);
      check("stall_result", out_result, 16'h7878);
      check("stall_valid", 16'(out_valid), 16'h1);
      step(0, 1, 1, 1, 4'h0, 16'h1234, 0, 16'h1111, 4'h7, 1, 1, 1);
      check("stallflush_valid", 16'(out_valid), 16'h0);
      check("stallflush_flags", 16'({flag_n, flag_z, flag_v}), 16'b101);

      // HLT then ADD zero
      step(0, 0, 0, 1, 4'hF, 16'h0042, 0, 16'h0, 4'h1, 1, 1, 1);
      check("hlt_halted", 16'(halted), 16'h1);
      check("hlt_row", 16'({out_valid, out_reg_wr, out_mem_rd, out_mem_wr}), 16'b1000);
      go(4'h0, 16'h0000, 0);
      check("post_hlt_valid", 16'(out_valid), 16'h0);
      check("post_hlt_z", 16'(flag_z), 16'h0);

      // Reset while halted
      step(1, 1, 1, 1, 4'h0, 16'h5555, 1, 16'h5555, 4'hF, 1, 1, 1);
      check("rst_halted", 16'(halted), 16'h0);
      check("rst_count", sat_count, 16'h0);
      check("rst_flags", 16'({flag_n, flag_z, flag_v}), 16'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         op = 4'($urandom_range(0, 15));
         if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'($urandom_range(0, 14));
         sample = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1,
              $urandom_range(0, 9) < 8, op, sample, 1'($urandom),
              16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      // Drive the saturation counter to its ceiling and past it
      step(1, 0, 0, 0, 4'h0, 16'h0, 0, 16'h0, 4'h0, 0, 0, 0);
      for (int i = 0; i < 65535; i++) go(4'h7, 16'h7878, 1);
      check("sat_ceiling", sat_count, 16'hFFFF);
      go(4'h7, 16'h7878, 1);
      check("sat_nowrap", sat_count, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
